vic_irq_controller: RTL

- Sequences delivery of 16 vectored IRQ lines and 1 non-vectored IRQ to the CPU core.
- Masks the vectored sources, then selects the winner by fixed priority: lowest index wins, non-vectored only when no vectored source is eligible.
- Runs a request/acknowledge/end-of-interrupt handshake with the CPU.
- Holds the selected handler number stable from request until end-of-interrupt.

---
 rtl/vic_irq_controller_if.sv | 23 ++
 rtl/vic_irq_controller.sv | 92 +++++++++
 2 files changed

// File: rtl/vic_irq_controller_if.sv
// vic_irq_controller_if: CPU/source-side bundle for the vectored interrupt controller
interface vic_irq_controller_if;
  logic [15:0] vIRQRequest;
  logic        nvIRQRequest;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic        cpu_ack;
  logic        cpu_eoi;
  logic        irq_o;
  logic [3:0]  handler_num;
  logic        is_nv;
  logic        in_service;
  logic [15:0] mask_o;
  logic [15:0] pending_o;
  modport master (
    output vIRQRequest, nvIRQRequest, mask_we, mask_wdata, cpu_ack, cpu_eoi,
    input  irq_o, handler_num, is_nv, in_service, mask_o, pending_o
  );
  modport slave (
    input  vIRQRequest, nvIRQRequest, mask_we, mask_wdata, cpu_ack, cpu_eoi,
    output irq_o, handler_num, is_nv, in_service, mask_o, pending_o
  );
endinterface

// File: rtl/vic_irq_controller.sv
// vic_irq_controller: masks 16 vectored IRQs plus one non-vectored IRQ, picks the
// lowest eligible index and runs a req/ack/eoi handshake with the CPU.
// Define VIC_EDGE_TRIGGER_EN to make vectored sources edge-triggered (sticky pending).
module vic_irq_controller #(
  parameter int NUM_VIRQ = 16
) (
  input logic clk,
  input logic rst_n,
  vic_irq_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_d;
  logic [NUM_VIRQ-1:0] mask, pending, pend_src, elig;
  logic [3:0] hnum, hnum_d, sel;
  logic nv, nv_d, cancel;
  assign elig = pend_src & mask;
`ifdef VIC_EDGE_TRIGGER_EN
  logic [NUM_VIRQ-1:0] hist, sticky, rise, ack_clr;
  assign rise = bus.vIRQRequest & ~hist;
  assign pend_src = sticky;
  // one-hot clear of the latched vectored source on the accepting ack
  always_comb begin
    ack_clr = '0;
    if (state == REQ && bus.cpu_ack && !nv) ack_clr[hnum] = 1'b1;
  end
  // line history and sticky pending bits; a fresh edge beats the ack clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist   <= '0;
      sticky <= '0;
    end else begin
      hist   <= bus.vIRQRequest;
      sticky <= (sticky & ~ack_clr) | (rise & mask);
    end
  end
`else
  assign pend_src = bus.vIRQRequest;
`endif
  // fixed priority: lowest eligible index wins
  always_comb begin
    sel = '0;
    for (int i = NUM_VIRQ - 1; i >= 0; i--) if (elig[i]) sel = 4'(i);
  end
  // next state and latched handler; selection is frozen outside IDLE
  always_comb begin
    state_d = state;
    hnum_d  = hnum;
    nv_d    = nv;
    cancel  = nv ? !bus.nvIRQRequest : !elig[hnum];
    case (state)
      IDLE: if (|elig || bus.nvIRQRequest) begin
        state_d = REQ;
        hnum_d  = |elig ? sel : 4'd0;
        nv_d    = ~|elig;
      end
      REQ: if (bus.cpu_ack) state_d = SERVICE;
      else if (cancel) begin
        state_d = IDLE;
        hnum_d  = '0;
        nv_d    = 1'b0;
      end
      SERVICE: if (bus.cpu_eoi) begin
        state_d = IDLE;
        hnum_d  = '0;
        nv_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, handler latch, mask and registered eligible set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      hnum    <= '0;
      nv      <= 1'b0;
      mask    <= '0;
      pending <= '0;
    end else begin
      state   <= state_d;
      hnum    <= hnum_d;
      nv      <= nv_d;
      pending <= elig;
      if (bus.mask_we) mask <= bus.mask_wdata;
    end
  end
  assign bus.irq_o       = state == REQ;
  assign bus.in_service  = state == SERVICE;
  assign bus.handler_num = hnum;
  assign bus.is_nv       = nv;
  assign bus.mask_o      = mask;
  assign bus.pending_o   = pending;
endmodule
